// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide. Divider is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       select,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH-1:0]   w_res1;
    logic [WIDTH-1:0]   w_res2;
    logic               w_ovf;
    logic               w_ill;
    logic               w_multi;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_sum = {1'b0, in1} + {1'b0, in2};
    assign w_dif = {1'b0, in1} - {1'b0, in2};

    // Single-cycle results are computed straight from the inputs and loaded on accept.
    always_comb begin
        w_res1  = '0;
        w_res2  = '0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        case (select)
            OP_ADD: begin
                w_res1 = w_sum[WIDTH-1:0];
                w_res2 = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
                w_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res1 = w_dif[WIDTH-1:0];
                w_res2 = {{(WIDTH-1){1'b0}}, w_dif[WIDTH]};
                w_ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_MUL: w_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: w_multi = 1'b1;
`endif
            OP_AND: w_res1 = in1 & in2;
            OP_OR:  w_res1 = in1 | in2;
            OP_XOR: w_res1 = in1 ^ in2;
            OP_SHL: w_res1 = in1 << in2[SHW-1:0];
            OP_SHR: w_res1 = in1 >> in2[SHW-1:0];
            default: w_ill = 1'b1;
        endcase
    end

    // Shift-add step: conditionally add A into the high half, then shift the pair right.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic             r_is_div;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Restoring step: bring in the next dividend bit, keep the difference if non-negative.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
    assign w_div_ok    = ~w_rem_diff[WIDTH];
    assign w_rem_next  = w_div_ok ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_div_ok};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_prod   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out1     <= '0;
            out2     <= '0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= 1'b0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_multi) begin
                            r_state <= S_CALC;
                            busy    <= 1'b1;
                            r_cnt   <= '0;
                            r_a     <= in1;
                            r_prod  <= {{WIDTH{1'b0}}, in2};
`ifdef ALU_SEQ_DIV_EN
                            r_is_div <= (select == OP_DIV);
                            r_b      <= in2;
                            r_rem    <= '0;
                            r_quo    <= in1;
`endif
                        end else begin
                            done     <= 1'b1;
                            out1     <= w_res1;
                            out2     <= w_res2;
                            overflow <= w_ovf;
                            illegal  <= w_ill;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_prod <= w_prod_next;
`ifdef ALU_SEQ_DIV_EN
                    r_rem  <= w_rem_next;
                    r_quo  <= w_quo_next;
`endif
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        illegal <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                        if (r_is_div) begin
                            if (r_b == '0) begin
                                out1     <= '1;
                                out2     <= r_a;
                                overflow <= 1'b1;
                            end else begin
                                out1     <= w_quo_next;
                                out2     <= w_rem_next;
                                overflow <= 1'b0;
                            end
                        end else
`endif
                        begin
                            out1     <= w_prod_next[WIDTH-1:0];
                            out2     <= w_prod_next[2*WIDTH-1:WIDTH];
                            overflow <= |w_prod_next[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16; expectations depend on ALU_SEQ_DIV_EN.
module tb_alu_seq;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  select = '0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        busy, done, overflow, illegal;
    logic [15:0] out1, out2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] o1;
        logic [15:0] o2;
        logic        ovf;
        logic        ill;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .select(select),
        .in1(in1), .in2(in2), .busy(busy), .done(done),
        .out1(out1), .out2(out2), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Every done pulse retires the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_out1"}, out1, mon_e.o1);
                check({mon_e.tag, "_out2"}, out2, mon_e.o2);
                check({mon_e.tag, "_ovf"}, overflow, mon_e.ovf);
                check({mon_e.tag, "_ill"}, illegal, mon_e.ill);
                $display("op %s: out1=%h out2=%h ovf=%b ill=%b", mon_e.tag, out1, out2, overflow, illegal);
            end
        end
    end

    task automatic run_op(input string tag, input logic [3:0] sel, input logic [15:0] a, b,
                          input logic [15:0] e1, e2, input logic eo, ei,
                          input int elat, input int poke);
        int  lat;
        bit  got_done;
        exp_q.push_back('{e1, e2, eo, ei, tag});
        @(negedge clk);
        start = 1'b1; select = sel; in1 = a; in2 = b;
        lat = 0; got_done = 0;
        while (!got_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            start = (poke != 0 && lat == poke);
            if (start) begin
                select = OP_ADD; in1 = 16'h0001; in2 = 16'h0001;
            end
            if (lat == 1) check({tag, "_busy"}, busy, elat > 1);
            if (done) got_done = 1;
        end
        check({tag, "_latency"}, lat, elat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b, e1, e2;
        logic [16:0] s;
        logic        eo;
        logic        en_div;
`ifdef ALU_SEQ_DIV_EN
        en_div = 1'b1;
`else
        en_div = 1'b0;
`endif
        // Asynchronous reset before the first clock edge
        start = 1'b1; select = 4'($urandom); in1 = 16'($urandom); in2 = 16'($urandom);
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out1", out1, 16'h0);
        check("rst_out2", out2, 16'h0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ill", illegal, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1, 0);
        run_op("sub_brw", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 0);
        run_op("mul_big", OP_MUL, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b1, 1'b0, 17, 0);
        run_op("mul_small", OP_MUL, 16'h0004, 16'h0004, 16'h0010, 16'h0000, 1'b0, 1'b0, 17, 0);
        if (en_div) begin
            run_op("div", OP_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17, 0);
            run_op("div_zero", OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 17, 0);
        end else begin
            run_op("div_off", OP_DIV, 16'h0064, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 0);
        end
        run_op("mul_poke", OP_MUL, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b1, 1'b0, 17, 3);

        // Abort a MUL with reset in its fifth cycle
        @(negedge clk);
        start = 1'b1; select = OP_MUL; in1 = 16'h00FF; in2 = 16'h00FF;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out1", out1, 16'h0);
        check("abort_out2", out2, 16'h0);
        check("abort_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op("add_after_abort", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0, 1'b0, 1, 0);

        run_op("shl15", OP_SHL, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 1, 0);
        run_op("shr4", OP_SHR, 16'h8000, 16'h0004, 16'h0800, 16'h0000, 1'b0, 1'b0, 1, 0);
        run_op("shl0", OP_SHL, 16'hA5A5, 16'h0010, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1, 0);
        run_op("illegal_c", 4'hC, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 0);
        run_op("and", OP_AND, 16'hFF00, 16'h0FF0, 16'h0F00, 16'h0000, 1'b0, 1'b0, 1, 0);
        run_op("or", OP_OR, 16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b0, 1'b0, 1, 0);

        // Back-to-back single-cycle starts
        exp_q.push_back('{16'h3333, 16'h0000, 1'b0, 1'b0, "b2b_add"});
        exp_q.push_back('{16'h0FF0, 16'h0000, 1'b0, 1'b0, "b2b_or"});
        @(negedge clk);
        start = 1'b1; select = OP_ADD; in1 = 16'h1111; in2 = 16'h2222;
        @(negedge clk);
        select = OP_OR; in1 = 16'h00F0; in2 = 16'h0F00;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random ADD/XOR against a small reference model
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i % 2 == 0) begin
                s  = {1'b0, a} + {1'b0, b};
                e1 = s[15:0];
                e2 = {15'h0, s[16]};
                eo = (a[15] == b[15]) && (s[15] != a[15]);
                run_op("rand_add", OP_ADD, a, b, e1, e2, eo, 1'b0, 1, 0);
            end else begin
                run_op("rand_xor", OP_XOR, a, b, a ^ b, 16'h0000, 1'b0, 1'b0, 1, 0);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
